// File: rtl/mips_mc_ctrl_if.sv
// Purpose: bundles the control-unit handshake and select signals between the controller and the datapath.
// Latency: wires only. The controller's outputs are combinational from its state and these inputs.
// Backpressure: mem_wait from the memory side stalls the controller in FETCH or in a memory EXEC2.
// Ports: start, instr, mem_wait, branch_taken and pc_is_zero flow into the controller.
//        The datapath enables and selects, active, illegal and bus_error flow out of it.
// master = controller side, slave = datapath/memory side.
interface mips_mc_ctrl_if #(
    parameter int ALUOP_W = 4
);
    logic               start;
    logic [31:0]        instr;
    logic               mem_wait;
    logic               branch_taken;
    logic               pc_is_zero;

    logic               ir_write;
    logic               iord;
    logic               alu_src_a;
    logic               alu_sel;
    logic               pc_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               tgt_write;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [2:0]         pc_src;
    logic [1:0]         reg_dst;
    logic               active;
    logic               illegal;
    logic               bus_error;

    modport master (
        input  start, instr, mem_wait, branch_taken, pc_is_zero,
        output ir_write, iord, alu_src_a, alu_sel, pc_write, reg_write, mem_to_reg,
               mem_read, mem_write, tgt_write, alu_src_b, alu_op, pc_src, reg_dst,
               active, illegal, bus_error
    );

    modport slave (
        output start, instr, mem_wait, branch_taken, pc_is_zero,
        input  ir_write, iord, alu_src_a, alu_sel, pc_write, reg_write, mem_to_reg,
               mem_read, mem_write, tgt_write, alu_src_b, alu_op, pc_src, reg_dst,
               active, illegal, bus_error
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Purpose: multicycle MIPS control FSM (HALTED/FETCH/DECODE/EXEC1-3) driving every datapath select and enable.
// Latency: with no wait states, ALU and immediate ops take 4 cycles, loads 5, stores 4, and jumps or branches 3.
// Backpressure: mem_wait holds FETCH or memory EXEC2. A run of WAIT_MAX waits sets sticky bus_error and halts.
// Ports: clk, rst_n (async, active-low) and bus (mips_mc_ctrl_if.master).
// Option: define BRANCH_DELAY_SLOT_EN to defer redirects through a saved target until after the delay slot.
module mips_mc_ctrl #(
    parameter int                 ALUOP_W  = 4,
    parameter int                 WAIT_MAX = 255,
    parameter logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(4'b0010),
    parameter logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(4'b0001),
    parameter logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(4'b0000),
    parameter logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(4'b0111),
    parameter logic [ALUOP_W-1:0] OP_PASSA = ALUOP_W'(4'b1110),
    parameter logic [ALUOP_W-1:0] OP_FUNCT = ALUOP_W'(4'b1111)
) (
    input  logic            clk,
    input  logic            rst_n,
    mips_mc_ctrl_if.master  bus
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {S_HALTED, S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_EXEC3} state_t;
    typedef enum logic [3:0] {C_RALU, C_JR, C_JALR, C_IMM, C_LOAD, C_STORE, C_J, C_JAL, C_BR, C_ILL} cls_t;

    state_t             state, nxt;
    cls_t               cls;
    logic [ALUOP_W-1:0] imm_op;
    logic               fetch_entry;   // first cycle of a FETCH visit; pc_is_zero is only honoured here
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_step, timeout, redirect;
    logic [2:0]         redir_src;
    logic               bus_error_q;
`ifdef BRANCH_DELAY_SLOT_EN
    logic               pending;       // a redirect target is saved and waits for the delay slot to finish
`endif

    wire [5:0] opcode = bus.instr[31:26];
    wire [5:0] funct  = bus.instr[5:0];
    logic unused_instr;
    assign unused_instr = ^bus.instr[25:6];

    // Instruction class decode
    always_comb begin
        cls    = C_ILL;
        imm_op = OP_ADD;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h2A: cls = C_RALU;
                    6'h08:                             cls = C_JR;
                    6'h09:                             cls = C_JALR;
                    default:                           cls = C_ILL;
                endcase
            end
            6'h09: begin cls = C_IMM; imm_op = OP_ADD; end
            6'h0C: begin cls = C_IMM; imm_op = OP_AND; end
            6'h0D: begin cls = C_IMM; imm_op = OP_OR;  end
            6'h0A: begin cls = C_IMM; imm_op = OP_SLT; end
            6'h23, 6'h20:        cls = C_LOAD;
            6'h2B:               cls = C_STORE;
            6'h02:               cls = C_J;
            6'h03:               cls = C_JAL;
            6'h04, 6'h05, 6'h07: cls = C_BR;
            default:             cls = C_ILL;
        endcase
    end

    // Next state and datapath controls
    always_comb begin
        nxt            = state;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_sel    = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.tgt_write  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_op     = '0;
        bus.pc_src     = 3'd0;
        bus.reg_dst    = 2'd0;
        bus.illegal    = 1'b0;
        redirect       = 1'b0;
        redir_src      = 3'd0;
        wait_step      = 1'b0;
        case (state)
            S_HALTED: if (bus.start) nxt = S_FETCH;
            S_FETCH: begin
                bus.alu_src_b = 2'd1;
                bus.alu_op    = OP_ADD;
                if (fetch_entry && bus.pc_is_zero) begin
                    nxt = S_HALTED;
                end else begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_wait) begin
                        wait_step = 1'b1;
                    end else begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
                        bus.pc_src   = pending ? 3'd4 : 3'd0;
`endif
                        nxt = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd3;
                bus.alu_op    = OP_ADD;
                nxt           = S_EXEC1;
            end
            S_EXEC1: begin
                nxt = S_FETCH;
                case (cls)
                    C_RALU: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_op    = OP_FUNCT;
                        nxt           = S_EXEC2;
                    end
                    C_JR, C_JALR: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_op    = OP_PASSA;
                        redirect      = 1'b1;
                        redir_src     = 3'd2;
                        if (cls == C_JALR) begin
                            bus.reg_write = 1'b1;   // link value is PC+4 via alu_sel=0
                            bus.reg_dst   = 2'd1;
                        end
                    end
                    C_IMM: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'd2;
                        bus.alu_op    = imm_op;
                        nxt           = S_EXEC2;
                    end
                    C_LOAD, C_STORE: begin
                        bus.alu_src_a = 1'b1;
                        bus.alu_src_b = 2'd2;
                        bus.alu_op    = OP_ADD;
                        nxt           = S_EXEC2;
                    end
                    C_J, C_JAL: begin
                        redirect  = 1'b1;
                        redir_src = 3'd1;
                        if (cls == C_JAL) begin
                            bus.reg_write = 1'b1;
                            bus.reg_dst   = 2'd2;
                        end
                    end
                    C_BR: begin
                        bus.alu_src_a = 1'b1;
                        if (bus.branch_taken) begin
                            redirect  = 1'b1;
                            redir_src = 3'd3;
                        end
                    end
                    default: bus.illegal = 1'b1;
                endcase
            end
            S_EXEC2: begin
                nxt = S_FETCH;
                case (cls)
                    C_RALU, C_IMM: begin
                        bus.reg_write = 1'b1;
                        bus.alu_sel   = 1'b1;
                        bus.reg_dst   = (cls == C_RALU) ? 2'd1 : 2'd0;
                    end
                    C_LOAD: begin
                        bus.iord     = 1'b1;
                        bus.mem_read = 1'b1;
                        if (bus.mem_wait) begin
                            wait_step = 1'b1;
                            nxt       = S_EXEC2;
                        end else begin
                            nxt = S_EXEC3;
                        end
                    end
                    C_STORE: begin
                        bus.iord      = 1'b1;
                        bus.mem_write = 1'b1;
                        if (bus.mem_wait) begin
                            wait_step = 1'b1;
                            nxt       = S_EXEC2;
                        end
                    end
                    default: nxt = S_FETCH;
                endcase
            end
            S_EXEC3: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                nxt            = S_FETCH;
            end
            default: nxt = S_HALTED;
        endcase

        if (redirect) begin
            bus.pc_src = redir_src;
`ifdef BRANCH_DELAY_SLOT_EN
            bus.tgt_write = 1'b1;
`else
            bus.pc_write  = 1'b1;
`endif
        end

        timeout = wait_step && (wait_cnt == CNT_W'(WAIT_MAX - 1));
        if (timeout) nxt = S_HALTED;

        // Nothing may write while reset is held, even transiently.
        if (!rst_n) begin
            bus.ir_write  = 1'b0;
            bus.pc_write  = 1'b0;
            bus.reg_write = 1'b0;
            bus.mem_write = 1'b0;
            bus.tgt_write = 1'b0;
            bus.mem_read  = 1'b0;
        end
    end

    assign bus.active    = (state != S_HALTED);
    assign bus.bus_error = bus_error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HALTED;
            fetch_entry <= 1'b0;
            wait_cnt    <= '0;
            bus_error_q <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pending     <= 1'b0;
`endif
        end else begin
            state       <= nxt;
            fetch_entry <= (nxt == S_FETCH) && (state != S_FETCH);
            if (timeout) begin
                bus_error_q <= 1'b1;
                wait_cnt    <= '0;
            end else if (wait_step) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
`ifdef BRANCH_DELAY_SLOT_EN
            if (redirect)
                pending <= 1'b1;
            else if (state == S_FETCH && nxt != S_FETCH)
                pending <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_mc_ctrl_if #(.ALUOP_W(4)) ifc ();
    mips_mc_ctrl #(.ALUOP_W(4), .WAIT_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam logic [31:0] ADDU  = 32'h0022_1821;
    localparam logic [31:0] ADDIU = 32'h2422_0005;
    localparam logic [31:0] ORI   = 32'h3422_00FF;
    localparam logic [31:0] LW    = 32'h8C22_0004;
    localparam logic [31:0] SW    = 32'hAC22_0004;
    localparam logic [31:0] BEQ   = 32'h1022_0003;
    localparam logic [31:0] JMP   = 32'h0800_0010;
    localparam logic [31:0] JAL   = 32'h0C00_0010;
    localparam logic [31:0] JR    = 32'h0020_0008;
    localparam logic [31:0] JALR  = 32'h0020_F809;
    localparam logic [31:0] BADOP = 32'hFC00_0000;
    localparam logic [31:0] BADFN = 32'h0000_003F;

    // enable order: ir_write iord alu_src_a alu_sel pc_write reg_write mem_to_reg mem_read mem_write tgt_write
    localparam logic [9:0] EN_0  = 10'b0000000000;
    localparam logic [9:0] EN_FX = 10'b1000100100;
    localparam logic [9:0] EN_FW = 10'b0000000100;
    localparam logic [9:0] EN_A  = 10'b0010000000;
    localparam logic [9:0] EN_WB = 10'b0001010000;
    localparam logic [9:0] EN_LD = 10'b0100000100;
    localparam logic [9:0] EN_ST = 10'b0100000010;
    localparam logic [9:0] EN_L3 = 10'b0000011000;
    localparam logic [9:0] EN_RW = 10'b0000010000;
    localparam logic [9:0] EN_AR = 10'b0010010000;

    typedef struct {
        logic [31:0] instr;
        logic        st, mw, bt, pz;
        logic [9:0]  en;
        logic [1:0]  sb;
        logic [3:0]  op;
        logic [2:0]  ps;
        logic [1:0]  rdst;
        logic        act, ill;
        logic        rd;   // redirect cycle
        logic        ds;   // fetch exit straight after a redirect
    } vec_t;

    vec_t tbl[$];
    int   errs = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic [31:0] i, input logic st, mw, bt, pz,
                                input logic [9:0] en, input logic [1:0] sb, input logic [3:0] op,
                                input logic [2:0] ps, input logic [1:0] rdst,
                                input logic act, ill, rd, ds);
        vec_t v;
        v.instr = i; v.st = st; v.mw = mw; v.bt = bt; v.pz = pz;
        v.en = en; v.sb = sb; v.op = op; v.ps = ps; v.rdst = rdst;
        v.act = act; v.ill = ill; v.rd = rd; v.ds = ds;
        return v;
    endfunction

    function automatic logic [23:0] outs();
        return {ifc.ir_write, ifc.iord, ifc.alu_src_a, ifc.alu_sel, ifc.pc_write, ifc.reg_write,
                ifc.mem_to_reg, ifc.mem_read, ifc.mem_write, ifc.tgt_write, ifc.alu_src_b,
                ifc.alu_op, ifc.pc_src, ifc.reg_dst, ifc.active, ifc.illegal, ifc.bus_error};
    endfunction

    function automatic logic [23:0] expect_of(input vec_t v);
        logic [9:0] en;
        logic [2:0] ps;
        en = v.en;
        if (v.rd) en = en | (DS ? 10'b0000000001 : 10'b0000100000);
        ps = (v.ds && DS) ? 3'd4 : v.ps;
        return {en, v.sb, v.op, ps, v.rdst, v.act, v.ill, 1'b0};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic st, mw, bt, pz);
        ifc.instr = i; ifc.start = st; ifc.mem_wait = mw; ifc.branch_taken = bt; ifc.pc_is_zero = pz;
    endtask

    task automatic fx(input logic [31:0] i, input logic ds);
        tbl.push_back(mk(i, 0, 0, 0, 0, EN_FX, 2'd1, 4'h2, 3'd0, 2'd0, 1, 0, 0, ds));
        tbl.push_back(mk(i, 0, 0, 0, 0, EN_0,  2'd3, 4'h2, 3'd0, 2'd0, 1, 0, 0, 0));
    endtask

    initial begin
        drive(ADDU, 1, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", {8'd0, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(ADDU, 0, 0, 0, 0);

        // idle, start
        tbl.push_back(mk(ADDU, 0, 0, 0, 0, EN_0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(ADDU, 1, 0, 0, 0, EN_0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ADDU
        fx(ADDU, 0);
        tbl.push_back(mk(ADDU, 0, 0, 0, 0, EN_A,  2'd0, 4'hF, 0, 2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(ADDU, 0, 0, 0, 0, EN_WB, 2'd0, 4'h0, 0, 2'd1, 1, 0, 0, 0));
        // ADDIU, ORI
        fx(ADDIU, 0);
        tbl.push_back(mk(ADDIU, 0, 0, 0, 0, EN_A,  2'd2, 4'h2, 0, 2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(ADDIU, 0, 0, 0, 0, EN_WB, 2'd0, 4'h0, 0, 2'd0, 1, 0, 0, 0));
        fx(ORI, 0);
        tbl.push_back(mk(ORI, 0, 0, 0, 0, EN_A,  2'd2, 4'h1, 0, 2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(ORI, 0, 0, 0, 0, EN_WB, 2'd0, 4'h0, 0, 2'd0, 1, 0, 0, 0));
        // LW: one fetch wait, three EXEC2 waits
        tbl.push_back(mk(LW, 0, 1, 0, 0, EN_FW, 2'd1, 4'h2, 0, 2'd0, 1, 0, 0, 0));
        fx(LW, 0);
        tbl.push_back(mk(LW, 0, 0, 0, 0, EN_A, 2'd2, 4'h2, 0, 2'd0, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(LW, 0, 1, 0, 0, EN_LD, 2'd0, 4'h0, 0, 2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(LW, 0, 0, 0, 0, EN_LD, 2'd0, 4'h0, 0, 2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(LW, 0, 0, 0, 0, EN_L3, 2'd0, 4'h0, 0, 2'd0, 1, 0, 0, 0));
        // SW with one wait
        fx(SW, 0);
        tbl.push_back(mk(SW, 0, 0, 0, 0, EN_A,  2'd2, 4'h2, 0, 2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(SW, 0, 1, 0, 0, EN_ST, 2'd0, 4'h0, 0, 2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(SW, 0, 0, 0, 0, EN_ST, 2'd0, 4'h0, 0, 2'd0, 1, 0, 0, 0));
        // BEQ not taken, then taken
        fx(BEQ, 0);
        tbl.push_back(mk(BEQ, 0, 0, 0, 0, EN_A, 2'd0, 4'h0, 0, 2'd0, 1, 0, 0, 0));
        fx(BEQ, 0);
        tbl.push_back(mk(BEQ, 0, 0, 1, 0, EN_A, 2'd0, 4'h0, 3'd3, 2'd0, 1, 0, 1, 0));
        // J, JAL, JALR
        fx(JMP, 1);
        tbl.push_back(mk(JMP, 0, 0, 0, 0, EN_0, 2'd0, 4'h0, 3'd1, 2'd0, 1, 0, 1, 0));
        fx(JAL, 1);
        tbl.push_back(mk(JAL, 0, 0, 0, 0, EN_RW, 2'd0, 4'h0, 3'd1, 2'd2, 1, 0, 1, 0));
        fx(JALR, 1);
        tbl.push_back(mk(JALR, 0, 0, 0, 0, EN_AR, 2'd0, 4'hE, 3'd2, 2'd1, 1, 0, 1, 0));
        // illegal opcode, illegal funct
        fx(BADOP, 1);
        tbl.push_back(mk(BADOP, 0, 0, 0, 0, EN_0, 2'd0, 4'h0, 0, 2'd0, 1, 1, 0, 0));
        fx(BADFN, 0);
        tbl.push_back(mk(BADFN, 0, 0, 0, 0, EN_0, 2'd0, 4'h0, 0, 2'd0, 1, 1, 0, 0));
        // fetch entry at PC 0 halts with no memory access
        tbl.push_back(mk(ADDU, 0, 0, 0, 1, EN_0, 2'd1, 4'h2, 0, 2'd0, 1, 0, 0, 0));
        tbl.push_back(mk(ADDU, 0, 0, 0, 0, EN_0, 2'd0, 4'h0, 0, 2'd0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].instr, tbl[i].st, tbl[i].mw, tbl[i].bt, tbl[i].pz);
            #1 check($sformatf("row%0d", i), {8'd0, outs()}, {8'd0, expect_of(tbl[i])});
        end

        // JR to address 0
        @(negedge clk); drive(JR, 1, 0, 0, 0);
        @(negedge clk); drive(JR, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1 check("jr_redirect", {29'd0, ifc.pc_write, ifc.tgt_write, 1'b0} | {29'd0, 3'b000},
                 {29'd0, ~DS, DS, 1'b0});
        check("jr_pc_src", {29'd0, ifc.pc_src}, 32'd2);
`ifdef BRANCH_DELAY_SLOT_EN
        @(negedge clk); drive(ADDIU, 0, 0, 0, 0);
        #1 check("ds_fetch", {29'd0, ifc.pc_write, ifc.ir_write, ifc.tgt_write}, 32'b110);
        check("ds_pc_src", {29'd0, ifc.pc_src}, 32'd4);
        repeat (3) @(negedge clk);
`endif
        @(negedge clk); drive(ADDU, 0, 0, 0, 1);
        #1 check("halt_fetch", {29'd0, ifc.mem_read, ifc.ir_write, ifc.pc_write}, 32'd0);
        @(negedge clk); drive(ADDU, 0, 0, 0, 0);
        #1 check("halt_active", {31'd0, ifc.active}, 32'd0);

        // wait-state timeout in FETCH (WAIT_MAX=4)
        @(negedge clk); drive(ADDU, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drive(ADDU, 0, 1, 0, 0);
        end
        #1 check("timeout_pre", {29'd0, ifc.bus_error, ifc.active, ifc.mem_read}, 32'b011);
        @(negedge clk);
        #1 check("timeout_post", {30'd0, ifc.bus_error, ifc.active}, 32'b10);
        @(negedge clk); drive(ADDU, 0, 0, 0, 0);
        #1 check("bus_error_sticky", {31'd0, ifc.bus_error}, 32'd1);
        rst_n = 1'b0;
        #1 check("bus_error_reset", {31'd0, ifc.bus_error}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // async reset in the middle of ADDU write-back
        @(negedge clk); drive(ADDU, 1, 0, 0, 0);
        @(negedge clk); drive(ADDU, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1 check("abort_pre", {31'd0, ifc.reg_write}, 32'd1);
        rst_n = 1'b0;
        #1 check("abort_post", {30'd0, ifc.reg_write, ifc.active}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        #1 check("abort_idle", {8'd0, outs()}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
